// File: rtl/coord_pkg.sv
// -----------------------------------------------------------------------------
// coord_pkg
// Shared types and helpers for the coordinate tracker:
//   lock_state_e  - lock state machine encoding (UNLOCK, LOCKED)
//   coord_t       - a (v, h) pair in plain 32-bit form for elaboration-time and
//                   combinational helper arithmetic
//   tap_offs_t    - per-tap line/pixel offsets derived from a latency
//   next_coord()  - raster successor of (v, h) in an H x W frame
//   tap_offsets() - constant function turning a tap latency into (DV, DH)
// -----------------------------------------------------------------------------
package coord_pkg;

  typedef enum logic {
    UNLOCK = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] h;
  } coord_t;

  typedef struct packed {
    logic [31:0] dv;
    logic [31:0] dh;
  } tap_offs_t;

  // Raster successor: step the pixel, carry into the line at end of line,
  // and wrap the line at end of frame.
  function automatic coord_t next_coord(input int unsigned v,
                                        input int unsigned h,
                                        input int unsigned height,
                                        input int unsigned width);
    coord_t c;
    if (h == width - 1) begin
      c.h = '0;
      c.v = (v == height - 1) ? '0 : v + 1;
    end else begin
      c.h = h + 1;
      c.v = v;
    end
    return c;
  endfunction

  // A tap of latency L shows the coordinate L-1 pixels behind its source.
  // The backward distance is reduced modulo the frame, then split into whole
  // lines (dv) and leftover pixels (dh).
  function automatic tap_offs_t tap_offsets(input int unsigned latency,
                                            input int unsigned height,
                                            input int unsigned width);
    tap_offs_t   o;
    int unsigned e;
    e    = (latency - 1) % (height * width);
    o.dv = e / width;
    o.dh = e % width;
    return o;
  endfunction

endpackage

// File: rtl/coord_tap.sv
// -----------------------------------------------------------------------------
// coord_tap
// One registered modulo subtractor: out = src - (DV lines + DH pixels),
// wrapped inside a FRAME_HEIGHT x FRAME_WIDTH raster, one cycle of latency.
// Ports:
//   clock     in   rising-edge clock
//   n_rst     in   synchronous active-low reset (outputs return to 0)
//   enable    in   clock enable; register holds when low
//   src_vcnt  in   source line counter
//   src_hcnt  in   source pixel counter
//   tap_vcnt  out  delayed line counter
//   tap_hcnt  out  delayed pixel counter
// -----------------------------------------------------------------------------
module coord_tap #(
  parameter  int FRAME_HEIGHT = 2,
  parameter  int FRAME_WIDTH  = 2,
  parameter  int DV           = 0,
  parameter  int DH           = 0,
  localparam int V_BITW       = $clog2(FRAME_HEIGHT),
  localparam int H_BITW       = $clog2(FRAME_WIDTH)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              enable,
  input  logic [V_BITW-1:0] src_vcnt,
  input  logic [H_BITW-1:0] src_hcnt,
  output logic [V_BITW-1:0] tap_vcnt,
  output logic [H_BITW-1:0] tap_hcnt
);

  // One extra bit on every intermediate so src + size - offset never wraps.
  localparam logic [V_BITW:0] H_X  = (V_BITW+1)'(FRAME_HEIGHT);
  localparam logic [H_BITW:0] W_X  = (H_BITW+1)'(FRAME_WIDTH);
  localparam logic [V_BITW:0] DV_X = (V_BITW+1)'(DV);
  localparam logic [H_BITW:0] DH_X = (H_BITW+1)'(DH);

  logic              borrow;
  logic [H_BITW:0]   src_h_x;
  logic [V_BITW:0]   src_v_x;
  logic [H_BITW:0]   h_x;
  logic [V_BITW:0]   d_x;
  logic [V_BITW:0]   v_x;
  logic [V_BITW-1:0] tap_v_q, tap_v_d;
  logic [H_BITW-1:0] tap_h_q, tap_h_d;

  always_comb begin
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    src_h_x = {1'b0, src_hcnt};
    src_v_x = {1'b0, src_vcnt};
    borrow  = (src_h_x < DH_X);
    h_x     = borrow ? (src_h_x + W_X - DH_X) : (src_h_x - DH_X);
    // A pixel borrow costs one extra line.
    d_x     = DV_X + {{V_BITW{1'b0}}, borrow};
    v_x     = (src_v_x < d_x) ? (src_v_x + H_X - d_x) : (src_v_x - d_x);
    tap_h_d = h_x[H_BITW-1:0];
    tap_v_d = v_x[V_BITW-1:0];
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      tap_v_q <= '0;
      tap_h_q <= '0;
    end else if (enable) begin
      tap_v_q <= tap_v_d;
      tap_h_q <= tap_h_d;
    end
  end

  assign tap_vcnt = tap_v_q;
  assign tap_hcnt = tap_h_q;

endmodule

// File: rtl/coord_tracker.sv
// -----------------------------------------------------------------------------
// coord_tracker
// Flywheel-stabilised multi-tap coordinate generator. A lock state machine
// checks that the incoming raster counters are continuous; once locked, every
// tap is fed from an internal free-running flywheel so a glitched or stalled
// input cannot disturb downstream stages.
// Ports:
//   clock     in   rising-edge clock
//   n_rst     in   synchronous active-low reset
//   enable    in   clock enable; all state holds when low, mismatch drops
//   in_vcnt   in   input line counter
//   in_hcnt   in   input pixel counter
//   out_vcnt  out  per-tap delayed line counter   [NUM_TAPS][V_BITW]
//   out_hcnt  out  per-tap delayed pixel counter  [NUM_TAPS][H_BITW]
//   locked    out  high while LOCKED
//   mismatch  out  one-cycle pulse per input/flywheel mismatch in LOCKED
//   err_cnt   out  saturating count of LOCKED mismatches
// -----------------------------------------------------------------------------
module coord_tracker
  import coord_pkg::*;
#(
  parameter  int FRAME_HEIGHT       = -1,
  parameter  int FRAME_WIDTH        = -1,
  parameter  int NUM_TAPS           = 1,
  parameter  int LATENCY [NUM_TAPS] = '{default: 1},
  parameter  int LOCK_COUNT         = 16,
  parameter  int MISS_LIMIT         = 4,
  localparam int V_BITW             = $clog2(FRAME_HEIGHT),
  localparam int H_BITW             = $clog2(FRAME_WIDTH)
) (
  input  logic                             clock,
  input  logic                             n_rst,
  input  logic                             enable,
  input  logic [V_BITW-1:0]                in_vcnt,
  input  logic [H_BITW-1:0]                in_hcnt,
  output logic [NUM_TAPS-1:0][V_BITW-1:0]  out_vcnt,
  output logic [NUM_TAPS-1:0][H_BITW-1:0]  out_hcnt,
  output logic                             locked,
  output logic                             mismatch,
  output logic [15:0]                      err_cnt
);

  localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W   = $clog2(MISS_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]   MISS_LAST   = MISS_W'(MISS_LIMIT - 1);

  lock_state_e         state_q;
  logic [V_BITW-1:0]   fw_v_q;
  logic [H_BITW-1:0]   fw_h_q;
  logic [STREAK_W-1:0] streak_q;
  logic [MISS_W-1:0]   miss_q;
  logic [15:0]         err_cnt_q;
  logic                mismatch_q;
  // Set by the first enabled cycle after reset: until then fw holds its reset
  // value rather than a prediction, so it must not count as a match.
  logic                primed_q;

  coord_t            in_nxt, fw_nxt;
  logic [V_BITW-1:0] in_next_v, fw_next_v, src_v;
  logic [H_BITW-1:0] in_next_h, fw_next_h, src_h;
  logic              match;

  always_comb begin
    in_nxt    = next_coord(32'(in_vcnt), 32'(in_hcnt), FRAME_HEIGHT, FRAME_WIDTH);
    fw_nxt    = next_coord(32'(fw_v_q), 32'(fw_h_q), FRAME_HEIGHT, FRAME_WIDTH);
    in_next_v = V_BITW'(in_nxt.v);
    in_next_h = H_BITW'(in_nxt.h);
    fw_next_v = V_BITW'(fw_nxt.v);
    fw_next_h = H_BITW'(fw_nxt.h);
    match     = primed_q && (in_vcnt == fw_v_q) && (in_hcnt == fw_h_q);
    // Once locked the taps follow the flywheel, never the raw input.
    src_v     = (state_q == LOCKED) ? fw_v_q : in_vcnt;
    src_h     = (state_q == LOCKED) ? fw_h_q : in_hcnt;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) begin
      state_q    <= UNLOCK;
      fw_v_q     <= '0;
      fw_h_q     <= '0;
      streak_q   <= '0;
      miss_q     <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      primed_q   <= 1'b0;
    end else if (!enable) begin
      mismatch_q <= 1'b0;
    end else begin
      primed_q   <= 1'b1;
      mismatch_q <= 1'b0;
      case (state_q)
        UNLOCK: begin
          // Predict the next input from the current one.
          fw_v_q <= in_next_v;
          fw_h_q <= in_next_h;
          miss_q <= '0;
          if (match) begin
            if (streak_q == STREAK_LAST) begin
              state_q  <= LOCKED;
              streak_q <= '0;
            end else begin
              streak_q <= streak_q + 1'b1;
            end
          end else begin
            streak_q <= '0;
          end
        end
        LOCKED: begin
          if (match) begin
            fw_v_q <= fw_next_v;
            fw_h_q <= fw_next_h;
            miss_q <= '0;
          end else begin
            mismatch_q <= 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (miss_q == MISS_LAST) begin
              // Give up on the flywheel and re-seed it from the new raster.
              state_q  <= UNLOCK;
              streak_q <= '0;
              miss_q   <= '0;
              fw_v_q   <= in_next_v;
              fw_h_q   <= in_next_h;
            end else begin
              miss_q <= miss_q + 1'b1;
              fw_v_q <= fw_next_v;
              fw_h_q <= fw_next_h;
            end
          end
        end
        default: state_q <= UNLOCK;
      endcase
    end
  end

  assign locked   = (state_q == LOCKED);
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam tap_offs_t OFFS = tap_offsets(LATENCY[k], FRAME_HEIGHT, FRAME_WIDTH);

    coord_tap #(
      .FRAME_HEIGHT (FRAME_HEIGHT),
      .FRAME_WIDTH  (FRAME_WIDTH),
      .DV           (int'(OFFS.dv)),
      .DH           (int'(OFFS.dh))
    ) u_tap (
      .clock    (clock),
      .n_rst    (n_rst),
      .enable   (enable),
      .src_vcnt (src_v),
      .src_hcnt (src_h),
      .tap_vcnt (out_vcnt[k]),
      .tap_hcnt (out_hcnt[k])
    );
  end

endmodule

// File: doc/coord_tracker.md
# coord_tracker

Multi-tap, flywheel-stabilised coordinate generator for the image_processor pipeline. It takes the raster counters (vcnt/hcnt, sync region included) from the timing generator and produces NUM_TAPS delayed coordinate pairs, one per pipeline stage latency, from a single shared block. A lock state machine verifies that the input raster is continuous. Once locked, all taps are driven from an internal free-running counter, so a glitched or stalled input coordinate cannot corrupt downstream stages.

## Interface
- FRAME_HEIGHT, -1: total lines per frame, sync included; must be >= 2.
- FRAME_WIDTH, -1: total pixels per line, sync included; must be >= 2.
- NUM_TAPS, 1: number of delayed coordinate outputs; must be >= 1.
- LATENCY, int array [NUM_TAPS], all 1: latency of each tap in cycles; each entry >= 1.
- LOCK_COUNT, 16: consecutive continuous input cycles required to lock; >= 1.
- MISS_LIMIT, 4: consecutive mismatches in LOCKED that force unlock; >= 1.
- V_BITW = $clog2(FRAME_HEIGHT), H_BITW = $clog2(FRAME_WIDTH): derived, not overridable.

Ports:
- clock  in  1  single clock; all logic is synchronous to its rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- enable  in  1  clock enable; when low, every register holds its value.
- in_vcnt  in  V_BITW  input line counter.
- in_hcnt  in  H_BITW  input pixel counter.
- out_vcnt  out  [NUM_TAPS][V_BITW]  per-tap delayed line counter.
- out_hcnt  out  [NUM_TAPS][H_BITW]  per-tap delayed pixel counter.
- locked  out  1  high while in the LOCKED state.
- mismatch  out  1  one-cycle pulse on an input/flywheel mismatch while LOCKED.
- err_cnt  out  16  saturating count of LOCKED mismatches.

## Operation
- next(v,h): h+1, except at h = FRAME_WIDTH-1, which gives h = 0 and v+1. v wraps from FRAME_HEIGHT-1 to 0.
- fw (fw_v, fw_h) is the expected current input coordinate. match = (in_vcnt == fw_v) && (in_hcnt == fw_h).
- State UNLOCK (after reset):
  - fw <= next(in).
  - On match, streak increments; on no match, streak is cleared.
  - When streak reaches LOCK_COUNT-1 and the current cycle matches, the state moves to LOCKED.
  - Tap source = in.
- State LOCKED:
  - fw <= next(fw), independent of in.
  - On no match: mismatch is pulsed, err_cnt increments (saturating at 0xFFFF), and miss increments.
  - When miss reaches MISS_LIMIT, the state moves to UNLOCK with streak = 0. In that same cycle fw <= next(in).
  - On match, miss is cleared.
  - Tap source = fw.
- Tap k computes src - (LATENCY[k]-1), modulo the frame, then registers it.
  - E = (LATENCY[k]-1) mod (H*W); DV = E / W; DH = E % W.
  - h: if src_h < DH, the result is src_h + W - DH; otherwise src_h - DH.
  - v: d = DV + (src_h < DH). If src_v < d, the result is src_v + H - d; otherwise src_v - d.
  - Intermediate sums carry one extra bit so they cannot overflow.
- A single glitched coordinate while LOCKED does not disturb the tap outputs.
- Out-of-range inputs (in_hcnt >= FRAME_WIDTH) simply fail to match. Tap outputs in UNLOCK are then undefined but remain in range only if the inputs are in range.

## Timing
- Reset values: out_vcnt/out_hcnt = 0 for all taps, locked = 0, mismatch = 0, err_cnt = 0, state = UNLOCK, fw = 0, streak = 0, miss = 0.
- Tap register latency is 1 cycle. On a continuous raster, out at cycle t equals the input coordinate at cycle t-LATENCY[k].
- locked rises in the cycle after the LOCK_COUNT-th consecutive match. A lock evaluation window starts only after the first post-reset input has loaded fw.
- mismatch is registered: it is high in the cycle after the offending input, for exactly one cycle per mismatching input.
- locked falls in the cycle after the MISS_LIMIT-th consecutive mismatch.
- enable low freezes fw, the state, and the counters. Outputs hold, and mismatch deasserts.
- Reset takes priority over enable.

## Structure
- Package coord_pkg holds:
  - the lock state enum (UNLOCK, LOCKED);
  - function next_coord(v, h, H, W);
  - constant function tap_offsets(latency, H, W), returning DV and DH.
- Sub-module coord_tap: one registered modulo subtractor with parameters DV, DH, FRAME_HEIGHT and FRAME_WIDTH. It is instantiated NUM_TAPS times in a generate loop.
- The top level contains the flywheel, the lock state machine, the counters and the source multiplexer.

## Test plan
All scenarios use FRAME_HEIGHT=525, FRAME_WIDTH=800, LATENCY={1,5,801}, LOCK_COUNT=4, MISS_LIMIT=2, unless stated otherwise.
- Reset mid-raster: drive (10,100) with n_rst low, then release. Outputs are 0 during reset. After release, locked rises 5 cycles after the first input. Tap outputs while in (10,120) is applied are (10,119), (10,115) and (9,119).
- Frame wrap: apply input (0,3) once locked. Taps read (0,3) first. Three cycles later, while (0,6) is applied, taps read (0,5), (0,1) and (524,5).
- Single glitch: while LOCKED, replace (50,400) with (0,0) for one cycle. Taps continue the sequence unbroken, mismatch pulses once, err_cnt = 1, and locked stays 1.
- Loss of lock: while LOCKED, jump the input from (50,400) to (200,0) and continue from there. mismatch fires 2 times and locked falls. Lock is then reacquired and taps restart from the new sequence.
- Enable stall: drop enable for 3 cycles with the input held. All outputs hold, mismatch stays 0, and counting resumes seamlessly.
- err_cnt saturation: force a mismatch pattern of 1 miss then 1 match, 70000 times. err_cnt stops at 0xFFFF and locked remains 1.
